// File: rtl/can_crc_engine_pkg.sv
// rtl/can_crc_engine_pkg.sv - shared FSM state type and CAN CRC-15/17/21 constants
package can_crc_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEND,
    ST_CHECK
  } state_e;

  localparam int          CRC15_W    = 15;
  localparam logic [14:0] CRC15_POLY = 15'h4599;
  localparam logic [14:0] CRC15_INIT = 15'h0000;

  localparam int          CRC17_W    = 17;
  localparam logic [16:0] CRC17_POLY = 17'h1685B;
  localparam logic [16:0] CRC17_INIT = 17'h10000;

  localparam int          CRC21_W    = 21;
  localparam logic [20:0] CRC21_POLY = 21'h102899;
  localparam logic [20:0] CRC21_INIT = 21'h100000;

endpackage

// File: rtl/can_crc_engine_if.sv
// rtl/can_crc_engine_if.sv - frame control, serial data and CRC result bundle
interface can_crc_engine_if #(
  parameter int CRC_W = 15
) ();

  logic             start;
  logic             mode_rx;
  logic             din;
  logic             din_vld;
  logic             din_last;
  logic             tx_rdy;
  logic [CRC_W-1:0] crc;
  logic             crc_done;
  logic             tx_bit;
  logic             tx_vld;
  logic             crc_ok;
  logic             crc_err;
  logic             busy;

  modport master (
    output start, mode_rx, din, din_vld, din_last, tx_rdy,
    input  crc, crc_done, tx_bit, tx_vld, crc_ok, crc_err, busy
  );

  modport slave (
    input  start, mode_rx, din, din_vld, din_last, tx_rdy,
    output crc, crc_done, tx_bit, tx_vld, crc_ok, crc_err, busy
  );

endinterface

// File: rtl/can_crc_engine_step.sv
// rtl/can_crc_engine_step.sv - one serial CAN CRC LFSR step
module can_crc_step
  import can_crc_engine_pkg::*;
#(
  parameter int               CRC_W = CRC15_W,
  parameter logic [CRC_W-1:0] POLY  = CRC15_POLY
) (
  input  logic [CRC_W-1:0] crc_in,
  input  logic             din,
  output logic [CRC_W-1:0] crc_out
);

  logic nxt;

  assign nxt     = din ^ crc_in[CRC_W-1];
  assign crc_out = {crc_in[CRC_W-2:0], 1'b0} ^ (nxt ? POLY : '0);

endmodule

// File: rtl/can_crc_engine.sv
// rtl/can_crc_engine.sv - CAN CRC generator/serialiser and receive checker
module can_crc_engine
  import can_crc_engine_pkg::*;
#(
  parameter int               CRC_W = CRC15_W,
  parameter logic [CRC_W-1:0] POLY  = CRC15_POLY,
  parameter logic [CRC_W-1:0] INIT  = '0
) (
  input logic              clk,
  input logic              rst,
  can_crc_engine_if.slave  bus
);

  localparam int               CNT_W    = $clog2(CRC_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CRC_W - 1);

  state_e           state_q;
  logic [CRC_W-1:0] crc_q;
  logic [CRC_W-1:0] work_q;
  logic [CRC_W-1:0] step_in;
  logic [CRC_W-1:0] step_out;
  logic [CNT_W-1:0] cnt_q;
  logic             mode_q;
  logic             done_q;
  logic             tx_vld_q;
  logic             ok_q;
  logic             err_q;

  // work_q is the check remainder in CHECK and the transmit shift register in SEND
  assign step_in = (state_q == ST_CHECK) ? work_q : crc_q;

  can_crc_step #(
    .CRC_W (CRC_W),
    .POLY  (POLY)
  ) u_step (
    .crc_in  (step_in),
    .din     (bus.din),
    .crc_out (step_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      crc_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      tx_vld_q <= 1'b0;
      ok_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      if (bus.start) begin
        state_q  <= ST_CALC;
        crc_q    <= INIT;
        work_q   <= '0;
        cnt_q    <= '0;
        mode_q   <= bus.mode_rx;
        tx_vld_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_CALC: if (bus.din_vld) begin
            crc_q <= step_out;
            if (bus.din_last) begin
              work_q <= step_out;
              done_q <= 1'b1;
              if (mode_q) begin
                state_q <= ST_CHECK;
              end else begin
                state_q  <= ST_SEND;
                tx_vld_q <= 1'b1;
              end
            end
          end
          ST_SEND: if (bus.tx_rdy) begin
            work_q <= {work_q[CRC_W-2:0], 1'b0};
            if (cnt_q == CNT_LAST) begin
              state_q  <= ST_IDLE;
              tx_vld_q <= 1'b0;
              cnt_q    <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          ST_CHECK: if (bus.din_vld) begin
            work_q <= step_out;
            if (cnt_q == CNT_LAST) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              ok_q    <= (step_out == '0);
              err_q   <= (step_out != '0);
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.crc      = crc_q;
  assign bus.crc_done = done_q;
  assign bus.tx_vld   = tx_vld_q;
  assign bus.tx_bit   = tx_vld_q & work_q[CRC_W-1];
  assign bus.crc_ok   = ok_q;
  assign bus.crc_err  = err_q;
  assign bus.busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_crc_engine.sv
// tb/tb_can_crc_engine.sv - directed CRC-15 vectors and CRC-17 loopback for can_crc_engine
module tb_can_crc_engine;
  import can_crc_engine_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_crc_engine_if #(.CRC_W(15)) b15 ();
  can_crc_engine_if #(.CRC_W(17)) btx ();
  can_crc_engine_if #(.CRC_W(17)) brx ();

  can_crc_engine u_dut15 (.clk(clk), .rst(rst), .bus(b15));
  can_crc_engine #(.CRC_W(17), .POLY(CRC17_POLY), .INIT(CRC17_INIT))
    u_tx17 (.clk(clk), .rst(rst), .bus(btx));
  can_crc_engine #(.CRC_W(17), .POLY(CRC17_POLY), .INIT(CRC17_INIT))
    u_rx17 (.clk(clk), .rst(rst), .bus(brx));

  int total = 0;
  int bad   = 0;
  int done15 = 0, ok15 = 0, err15 = 0, ok17 = 0, err17 = 0;

  always @(negedge clk) begin
    if (b15.crc_done) done15++;
    if (b15.crc_ok)   ok15++;
    if (b15.crc_err)  err15++;
    if (brx.crc_ok)   ok17++;
    if (brx.crc_err)  err17++;
  end

  typedef struct {
    int          n;
    logic [63:0] bits;
    logic [14:0] crc;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // din_vld is raised together with start to confirm start wins
  task automatic start15(input logic rx);
    b15.start = 1'b1; b15.mode_rx = rx;
    b15.din = 1'b1; b15.din_vld = 1'b1; b15.din_last = 1'b0;
    tick();
    b15.start = 1'b0; b15.din_vld = 1'b0;
  endtask

  task automatic feed15(input int n, input logic [63:0] bits);
    for (int i = 0; i < n; i++) begin
      b15.din = bits[6'(n - 1 - i)];
      b15.din_vld = 1'b1;
      b15.din_last = (i == n - 1);
      tick();
    end
    b15.din_vld = 1'b0; b15.din_last = 1'b0;
  endtask

  task automatic collect15(input logic toggle, output logic [14:0] word, output int nacc,
                           output logic stall_ok, output logic vld_ok);
    logic prev, acc;
    word = '0; nacc = 0; stall_ok = 1'b1; vld_ok = 1'b1;
    for (int c = 0; c < 80 && nacc < 15; c++) begin
      b15.tx_rdy = toggle ? c[0] : 1'b1;
      if (!b15.tx_vld || !b15.busy) vld_ok = 1'b0;
      prev = b15.tx_bit;
      acc  = b15.tx_rdy && b15.tx_vld;
      if (acc) begin
        word = {word[13:0], b15.tx_bit};
        nacc++;
      end
      tick();
      if (!acc && b15.tx_bit !== prev) stall_ok = 1'b0;
    end
    b15.tx_rdy = 1'b0;
  endtask

  task automatic tx_check(input string tag, input logic toggle, input logic [14:0] exp);
    logic [14:0] word;
    int          nacc;
    logic        stall_ok, vld_ok;
    collect15(toggle, word, nacc, stall_ok, vld_ok);
    chk({tag, "_txword"}, 32'(word), 32'(exp));
    chk({tag, "_txcount"}, nacc, 15);
    chk({tag, "_stall_vld"}, {stall_ok, vld_ok}, 2'b11);
    chk({tag, "_idle_after"}, {b15.busy, b15.tx_vld}, 2'b00);
    chk({tag, "_crc_held"}, 32'(b15.crc), 32'(exp));
  endtask

  task automatic rx15(input string tag, input logic [14:0] crcbits, input logic exp_ok);
    int o0, e0;
    o0 = ok15; e0 = err15;
    start15(1'b1);
    feed15(1, 64'd1);
    for (int i = 0; i < 15; i++) begin
      b15.din = crcbits[4'(14 - i)];
      b15.din_vld = 1'b1;
      b15.din_last = 1'b1;
      tick();
    end
    b15.din_vld = 1'b0; b15.din_last = 1'b0;
    chk({tag, "_pulse"}, {b15.crc_ok, b15.crc_err}, {exp_ok, !exp_ok});
    chk({tag, "_crc_kept"}, 32'(b15.crc), 32'h4599);
    tick();
    chk({tag, "_pulse_end"}, {b15.crc_ok, b15.crc_err, b15.busy}, 3'b000);
    chk({tag, "_ok_cnt"}, ok15 - o0, exp_ok ? 1 : 0);
    chk({tag, "_err_cnt"}, err15 - e0, exp_ok ? 0 : 1);
  endtask

  function automatic logic [16:0] gold17(input int n, input logic [63:0] bits);
    logic [16:0] c;
    c = CRC17_INIT;
    for (int i = n - 1; i >= 0; i--) begin
      if (bits[i] ^ c[16]) c = {c[15:0], 1'b0} ^ CRC17_POLY;
      else                 c = {c[15:0], 1'b0};
    end
    return c;
  endfunction

  initial begin
    int          d0, o0, e0, n, nacc;
    logic [63:0] bits;
    logic [16:0] g, word17;

    vt[0] = '{1, 64'b1,   15'h4599};
    vt[1] = '{2, 64'b10,  15'h4EAB};
    vt[2] = '{1, 64'b0,   15'h0000};
    vt[3] = '{2, 64'b01,  15'h4599};
    vt[4] = '{2, 64'b11,  15'h0B32};
    vt[5] = '{3, 64'b100, 15'h58CF};
    vt[6] = '{3, 64'b101, 15'h1D56};

    {b15.start, b15.mode_rx, b15.din, b15.din_vld, b15.din_last, b15.tx_rdy} = '0;
    {btx.start, btx.mode_rx, btx.din, btx.din_vld, btx.din_last, btx.tx_rdy} = '0;
    {brx.start, brx.mode_rx, brx.din, brx.din_vld, brx.din_last, brx.tx_rdy} = '0;

    tick(); tick();
    chk("reset_outputs", {17'(b15.crc), b15.crc_done, b15.tx_bit, b15.tx_vld,
                          b15.crc_ok, b15.crc_err, b15.busy}, '0);
    rst = 1'b0;
    tick();

    b15.din = 1'b1; b15.din_vld = 1'b1;
    tick(); tick();
    b15.din_vld = 1'b0;
    chk("idle_din_ignored", {b15.busy, 15'(b15.crc)}, '0);

    for (int v = 0; v < 7; v++) begin
      d0 = done15;
      start15(1'b0);
      chk($sformatf("v%0d_start_init", v), {b15.busy, 15'(b15.crc)}, {1'b1, 15'h0});
      feed15(vt[v].n, vt[v].bits);
      chk($sformatf("v%0d_crc", v), 32'(b15.crc), 32'(vt[v].crc));
      chk($sformatf("v%0d_done_now", v), b15.crc_done, 1);
      tx_check($sformatf("v%0d", v), 1'b0, vt[v].crc);
      chk($sformatf("v%0d_done_once", v), done15 - d0, 1);
    end

    // tx_rdy toggling, with din_vld held high to show SEND ignores it
    start15(1'b0);
    feed15(1, 64'd1);
    b15.din = 1'b1; b15.din_vld = 1'b1;
    tx_check("toggle", 1'b1, 15'h4599);
    b15.din_vld = 1'b0;

    rx15("rx_good", 15'h4599, 1'b1);
    rx15("rx_flip8", 15'h4519, 1'b0);

    // reset in the middle of CALC
    start15(1'b0);
    b15.din = 1'b1; b15.din_vld = 1'b1;
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_calc", {b15.busy, 15'(b15.crc), b15.tx_vld, b15.crc_done}, '0);
    b15.din_vld = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    start15(1'b0);
    feed15(1, 64'd1);
    chk("after_rst_crc", 32'(b15.crc), 32'h4599);
    tx_check("after_rst", 1'b0, 15'h4599);

    // start in the middle of CHECK aborts without a verdict
    o0 = ok15; e0 = err15;
    start15(1'b1);
    feed15(1, 64'd1);
    feed15(5, 64'b10001);
    start15(1'b0);
    chk("abort_check", {b15.busy, 15'(b15.crc), b15.crc_ok, b15.crc_err}, {1'b1, 15'h0, 2'b00});
    feed15(1, 64'd1);
    tx_check("after_abort", 1'b0, 15'h4599);
    tick(); tick();
    chk("abort_no_verdict", {16'(ok15 - o0), 16'(err15 - e0)}, '0);

    e0 = err17;
    for (int f = 0; f < 1000; f++) begin
      n    = $urandom_range(64, 1);
      bits = {$urandom(), $urandom()};
      g    = gold17(n, bits);
      o0   = ok17;
      btx.start = 1'b1; brx.start = 1'b1; btx.mode_rx = 1'b0; brx.mode_rx = 1'b1;
      tick();
      btx.start = 1'b0; brx.start = 1'b0;
      for (int i = 0; i < n; i++) begin
        btx.din = bits[6'(n - 1 - i)]; brx.din = btx.din;
        btx.din_vld = 1'b1; brx.din_vld = 1'b1;
        btx.din_last = (i == n - 1); brx.din_last = btx.din_last;
        tick();
      end
      {btx.din_vld, btx.din_last, brx.din_vld, brx.din_last} = '0;
      chk($sformatf("f%0d_tx_crc", f), 32'(btx.crc), 32'(g));
      chk($sformatf("f%0d_rx_crc", f), 32'(brx.crc), 32'(g));
      btx.tx_rdy = 1'b1;
      word17 = '0; nacc = 0;
      for (int c = 0; c < 40 && nacc < 17; c++) begin
        brx.din = btx.tx_bit; brx.din_vld = btx.tx_vld;
        if (btx.tx_vld) begin
          word17 = {word17[15:0], btx.tx_bit};
          nacc++;
        end
        tick();
      end
      brx.din_vld = 1'b0; btx.tx_rdy = 1'b0;
      tick();
      chk($sformatf("f%0d_tx_word", f), 32'(word17), 32'(g));
      chk($sformatf("f%0d_rx_ok", f), ok17 - o0, 1);
    end
    chk("loopback_no_err", err17 - e0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/can_crc_engine.md
CAN_CRC_ENGINE -- requirements
Module: can_crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 15, meaning CRC register width (15 for CAN 2.0, 17 or 21 for CAN FD).
REQ-002 SHALL have parameter POLY, default 15'h4599, meaning generator polynomial without the implicit x^CRC_W term (CAN FD values: 17'h1685B, 21'h102899).
REQ-003 SHALL have parameter INIT, default 0, meaning CRC register value loaded on start (CAN FD: 1 << (CRC_W-1)).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse: load INIT and begin a new frame.
REQ-007 mode_rx  in  1  sampled with start: 0 = transmit (generate and serialise CRC), 1 = receive (check CRC).
REQ-008 din  in  1  serial bit, MSB-first frame order.
REQ-009 din_vld  in  1  din is consumed this cycle.
REQ-010 din_last  in  1  qualifies din_vld: last data bit before the CRC field.
REQ-011 tx_rdy  in  1  downstream accepts tx_bit this cycle.
REQ-012 crc  out  CRC_W  computed CRC, held after data phase.
REQ-013 crc_done  out  1  one-cycle pulse when the data phase ends.
REQ-014 tx_bit  out  1  serialised CRC bit, MSB first.
REQ-015 tx_vld  out  1  tx_bit is valid.
REQ-016 crc_ok  out  1  one-cycle pulse: received CRC matched.
REQ-017 crc_err  out  1  one-cycle pulse: received CRC mismatched.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> CALC -> (SEND | CHECK) -> IDLE.
REQ-020 LFSR step SHALL be: nxt = din XOR crc[CRC_W-1]; crc <= (crc << 1) truncated to CRC_W bits, XOR POLY when nxt = 1; applied only on cycles where din_vld = 1.
REQ-021 start SHALL have priority in every state: load INIT, clear counters, latch mode_rx, enter CALC; same-cycle din_vld is ignored.
REQ-022 CALC: din_vld && din_last SHALL apply that bit's step, then go to SEND if mode_rx = 0 or CHECK if mode_rx = 1.
REQ-023 crc_done SHALL pulse on the cycle after the last-bit step, and crc SHALL hold the final value from then on.
REQ-024 SEND: tx_vld = 1 and tx_bit = crc bit (CRC_W-1-cnt), where cnt counts bits accepted on tx_vld && tx_rdy.
REQ-025 SEND: after CRC_W accepted bits, SHALL return to IDLE with tx_vld = 0; tx_rdy low stalls with tx_bit stable.
REQ-026 CHECK: received CRC bits SHALL be fed through the same LFSR step on din_vld; din_last is ignored in this state.
REQ-027 CHECK: after CRC_W bits, SHALL pulse crc_ok if the register is all zero, otherwise crc_err (exactly one of the two), then go to IDLE.
REQ-028 The check remainder SHALL NOT overwrite the crc output; CHECK uses a working copy.
REQ-029 din_vld in IDLE or SEND SHALL be ignored.
REQ-030 Bit counter width SHALL be $clog2(CRC_W+1) and SHALL never wrap within a phase.
REQ-031 A start during SEND or CHECK SHALL abort the phase with no crc_ok or crc_err pulse.

Reset
REQ-032 rst SHALL asynchronously force IDLE, crc = 0, working register = 0, counter = 0, and all 1-bit outputs = 0.
REQ-033 rst mid-frame SHALL discard the frame; the first start after deassertion SHALL behave as from power-up.

Structure
REQ-034 A shared package SHALL hold the state enum and the polynomial and init constants for CRC-15, CRC-17 and CRC-21.
REQ-035 The LFSR step SHALL be a single sub-module, can_crc_step (combinational: crc_in, din -> crc_out), instantiated once and shared by CALC and CHECK.

Verification
REQ-036 CRC_W=15, INIT=0, mode_rx=0: start, then single bit 1 with din_last -> crc = 15'h4599, crc_done once, tx_bit sequence 100010110011001 over 15 accepted cycles.
REQ-037 Two bits 1,0 (last on the second) -> crc = 15'h4EAB.
REQ-038 mode_rx=1: bit 1 (last), then the 15 bits 100010110011001 -> crc_ok pulse; flip the 8th CRC bit -> crc_err pulse, crc_ok stays low.
REQ-039 SEND with tx_rdy toggling 0/1 each cycle -> same 15-bit sequence, each bit held while tx_rdy = 0, busy falls after the 15th accept.
REQ-040 rst asserted mid-CALC, and start asserted mid-CHECK -> outputs cleared immediately and no crc_ok or crc_err; the new frame matches REQ-036.
REQ-041 CRC_W=17, POLY=17'h1685B, INIT=17'h10000 -> golden-model comparison over 1000 random frames (length 1-64 bits), transmit and loopback receive, crc_ok on every frame.
